// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debouncer and press/release/long-press pulse generator
module button_channel #(
   parameter int DB_CYCLES   = 480000,
   parameter int LONG_CYCLES = 24000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic level,
   output logic press,
   output logic rel,
   output logic lng
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
   // bit 0 of the state encoding is the debounced level itself
   typedef enum logic [1:0] {
      S_RELEASED  = 2'b00,
      S_HELD      = 2'b01,
      S_LONG_HELD = 2'b11
   } state_t;
   state_t state_q, state_d;
   logic sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic press_q, press_d, rel_q, rel_d, long_q, long_d;
   logic pressed, flip;
   always_comb begin
      pressed = ~sync2_q;
      flip    = (pressed != state_q[0]) && (cnt_q == DB_MAX);
      cnt_d   = (pressed == state_q[0] || flip) ? '0 : cnt_q + 1'b1;
      hold_d  = flip ? '0 : (state_q[0] && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
      long_d  = !flip && state_q == S_HELD && hold_d == HOLD_MAX;
      state_d = flip ? (pressed ? S_HELD : S_RELEASED) : long_d ? S_LONG_HELD : state_q;
      press_d = flip && pressed;
      rel_d   = flip && !pressed;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         hold_q  <= '0;
         state_q <= S_RELEASED;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync1_q <= raw_n;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         state_q <= state_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
      end
   end
   assign level = state_q[0];
   assign press = press_q;
   assign rel   = rel_q;
   assign lng   = long_q;
endmodule

module button_conditioner #(
   parameter int DB_CYCLES   = 480000,
   parameter int LONG_CYCLES = 24000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_a,
   input  logic button_b,
   output logic a_level,
   output logic a_press,
   output logic a_release,
   output logic a_long,
   output logic b_level,
   output logic b_press,
   output logic b_release,
   output logic b_long
);
   button_channel #(.DB_CYCLES(DB_CYCLES), .LONG_CYCLES(LONG_CYCLES)) u_a (
      .clk(clk), .rst_n(rst_n), .raw_n(button_a),
      .level(a_level), .press(a_press), .rel(a_release), .lng(a_long)
   );
   button_channel #(.DB_CYCLES(DB_CYCLES), .LONG_CYCLES(LONG_CYCLES)) u_b (
      .clk(clk), .rst_n(rst_n), .raw_n(button_b),
      .level(b_level), .press(b_press), .rel(b_release), .lng(b_long)
   );
endmodule
